// File: rtl/led_pattern_gen_multi.sv
// HUB75-style split-panel row generator: PWM-coded RGB bit-planes per row, effects stepped on frame wraps.
// Build option: define LED_PATGEN_GAMMA_EN to apply gamma 2.0 to intensities before the PWM compare.
module led_pattern_gen_multi #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 16,
  parameter int COLOUR_W     = 4,
  parameter int EFFECT_TICKS = 1_000_000,
  parameter int ADDR_W       = $clog2(NUM_ROWS)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [3*COLOUR_W-1:0] colour_in,
  input  logic [3:0]            mode_in,
  output logic [3*NUM_COLS-1:0] row_top_out,
  output logic [3*NUM_COLS-1:0] row_bot_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ADDR_W-1:0]     row_address_out,
  output logic                  frame_done_out
);

  localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int LINE_W = $clog2(2 * NUM_ROWS);
  localparam int TICK_W = (EFFECT_TICKS > 1) ? $clog2(EFFECT_TICKS) : 1;
  localparam logic [COLOUR_W-1:0] IMAX     = '1;
  localparam logic [COLOUR_W-1:0] PWM_LAST = IMAX - 1'b1;

  localparam logic [3:0] M_SOLID = 4'd1;
  localparam logic [3:0] M_HSCAN = 4'd2;
  localparam logic [3:0] M_VSCAN = 4'd3;
  localparam logic [3:0] M_PULSE = 4'd4;
  localparam logic [3:0] M_CHECK = 4'd5;

  logic [3:0]            mode_buf_q;
  logic                  valid_q, valid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  fdone_q, fdone_d;
  logic [3*NUM_COLS-1:0] top_q, top_d, bot_q, bot_d;
  logic [COL_W-1:0]      hpos_q, hpos_d;
  logic                  hdir_q, hdir_d;
  logic [LINE_W-1:0]     vpos_q, vpos_d;
  logic                  vdir_q, vdir_d;
  logic [COLOUR_W-1:0]   fade_q, fade_d;
  logic                  fdir_q, fdir_d;
  logic                  phase_q, phase_d;
  logic [COLOUR_W-1:0]   pwm_q, pwm_d;
  logic                  pending_q, pending_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  rst_dly_q;

  logic                  mode_chg, xfer, last_row, tick, load;
  int                    h_n, v_n, f_n;
  logic                  hdir_n, vdir_n, fdir_n;
  logic [LINE_W-1:0]     line_top, line_bot;
  logic [3*NUM_COLS-1:0] row_top_n, row_bot_n;

  // dir 0 = counting up, 1 = counting down; reverses on reaching either end
  function automatic void bounce(input int pos, input logic dir, input int maxv,
                                 output int npos, output logic ndir);
    ndir = dir;
    if (maxv == 0) begin
      npos = 0;
    end else if (!dir) begin
      if (pos == maxv) begin
        npos = pos - 1;
        ndir = 1'b1;
      end else begin
        npos = pos + 1;
      end
    end else begin
      if (pos == 0) begin
        npos = 1;
        ndir = 1'b0;
      end else begin
        npos = pos - 1;
      end
    end
  endfunction

  function automatic logic [COLOUR_W-1:0] pix(
    input logic [3:0]          m,
    input logic [COL_W-1:0]    col,
    input logic [LINE_W-1:0]   line,
    input logic [COLOUR_W-1:0] c,
    input logic [COL_W-1:0]    hp,
    input logic [LINE_W-1:0]   vp,
    input logic [COLOUR_W-1:0] fd,
    input logic                ph
  );
    logic [2*COLOUR_W-1:0] prod;
    logic [COLOUR_W-1:0]   i;
`ifdef LED_PATGEN_GAMMA_EN
    logic [2*COLOUR_W-1:0] sq;
`endif
    prod = {{COLOUR_W{1'b0}}, c} * {{COLOUR_W{1'b0}}, fd};
    i = '0;
    case (m)
      M_SOLID: i = c;
      M_HSCAN: i = (col == hp) ? c : '0;
      M_VSCAN: i = (line == vp) ? c : '0;
      M_PULSE: i = COLOUR_W'(prod >> COLOUR_W);
      M_CHECK: i = (col[0] ^ line[0] ^ ph) ? c : '0;
      default: i = '0;
    endcase
`ifdef LED_PATGEN_GAMMA_EN
    sq = {{COLOUR_W{1'b0}}, i} * {{COLOUR_W{1'b0}}, i};
    i  = (i == IMAX) ? IMAX : COLOUR_W'(sq >> COLOUR_W);
`endif
    return i;
  endfunction

  always_comb begin
    mode_chg = (mode_in != mode_buf_q);
    xfer     = valid_q & row_ready_in;
    last_row = (addr_q == ADDR_W'(NUM_ROWS - 1));
    tick     = (tick_q == TICK_W'(EFFECT_TICKS - 1));
    bounce(int'(hpos_q), hdir_q, NUM_COLS - 1, h_n, hdir_n);
    bounce(int'(vpos_q), vdir_q, 2 * NUM_ROWS - 1, v_n, vdir_n);
    bounce(int'(fade_q), fdir_q, int'(IMAX), f_n, fdir_n);

    tick_d    = tick ? '0 : tick_q + 1'b1;
    valid_d   = valid_q;
    addr_d    = addr_q;
    fdone_d   = 1'b0;
    hpos_d    = hpos_q;
    hdir_d    = hdir_q;
    vpos_d    = vpos_q;
    vdir_d    = vdir_q;
    fade_d    = fade_q;
    fdir_d    = fdir_q;
    phase_d   = phase_q;
    pwm_d     = pwm_q;
    pending_d = pending_q | tick;
    load      = 1'b0;

    if (mode_chg) begin
      valid_d   = 1'b0;
      addr_d    = '0;
      hpos_d    = '0;
      hdir_d    = 1'b0;
      vpos_d    = '0;
      vdir_d    = 1'b0;
      fade_d    = '0;
      fdir_d    = 1'b0;
      phase_d   = 1'b0;
      pwm_d     = '0;
      pending_d = 1'b0;
    end else if (!valid_q) begin
      if (!rst_dly_q) begin
        valid_d = 1'b1;
        addr_d  = '0;
        load    = 1'b1;
      end
    end else if (xfer) begin
      load = 1'b1;
      if (last_row) begin
        // frame wrap: the only point where effect state and PWM phase may move
        addr_d    = '0;
        fdone_d   = 1'b1;
        pwm_d     = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
        pending_d = tick;
        if (pending_q) begin
          hpos_d  = COL_W'(h_n);
          hdir_d  = hdir_n;
          vpos_d  = LINE_W'(v_n);
          vdir_d  = vdir_n;
          fade_d  = COLOUR_W'(f_n);
          fdir_d  = fdir_n;
          phase_d = ~phase_q;
        end
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    line_top  = LINE_W'(addr_d);
    line_bot  = line_top + LINE_W'(NUM_ROWS);
    row_top_n = '0;
    row_bot_n = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        row_top_n[ch*NUM_COLS + c] = pix(mode_buf_q, COL_W'(c), line_top,
                                         colour_in[ch*COLOUR_W +: COLOUR_W],
                                         hpos_d, vpos_d, fade_d, phase_d) > pwm_d;
        row_bot_n[ch*NUM_COLS + c] = pix(mode_buf_q, COL_W'(c), line_bot,
                                         colour_in[ch*COLOUR_W +: COLOUR_W],
                                         hpos_d, vpos_d, fade_d, phase_d) > pwm_d;
      end
    end
    top_d = load ? row_top_n : top_q;
    bot_d = load ? row_bot_n : bot_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mode_buf_q <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      fdone_q    <= 1'b0;
      top_q      <= '0;
      bot_q      <= '0;
      hpos_q     <= '0;
      hdir_q     <= 1'b0;
      vpos_q     <= '0;
      vdir_q     <= 1'b0;
      fade_q     <= '0;
      fdir_q     <= 1'b0;
      phase_q    <= 1'b0;
      pwm_q      <= '0;
      pending_q  <= 1'b0;
      tick_q     <= '0;
      rst_dly_q  <= 1'b1;
    end else begin
      mode_buf_q <= mode_in;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      fdone_q    <= fdone_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      hpos_q     <= hpos_d;
      hdir_q     <= hdir_d;
      vpos_q     <= vpos_d;
      vdir_q     <= vdir_d;
      fade_q     <= fade_d;
      fdir_q     <= fdir_d;
      phase_q    <= phase_d;
      pwm_q      <= pwm_d;
      pending_q  <= pending_d;
      tick_q     <= tick_d;
      rst_dly_q  <= 1'b0;
    end
  end

  assign row_top_out     = top_q;
  assign row_bot_out     = bot_q;
  assign row_valid_out   = valid_q;
  assign row_address_out = addr_q;
  assign frame_done_out  = fdone_q;

endmodule

// File: tb/tb_led_pattern_gen_multi.sv
// Bench for led_pattern_gen_multi: constant vector table, hand sequences, and a randomized run against a frame-level model.
module tb_led_pattern_gen_multi;
  localparam int NC = 8;
  localparam int NR = 16;
  localparam int CW = 4;
  localparam int ET = 4;
  localparam int AW = $clog2(NR);
  localparam int IMAXV   = (1 << CW) - 1;
  localparam int NPHASES = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_in = 1'b1;
  logic [3*CW-1:0] colour = '0;
  logic [3:0]      mode = '0;
  logic            ready = 1'b0;
  logic [3*NC-1:0] top_o, bot_o;
  logic            valid_o, fd_o;
  logic [AW-1:0]   addr_o;

  int n_vec = 0;
  int n_fail = 0;

  led_pattern_gen_multi #(.NUM_COLS(NC), .NUM_ROWS(NR), .COLOUR_W(CW), .EFFECT_TICKS(ET)) dut (
    .clk_in(clk), .reset_in(rst_in), .colour_in(colour), .mode_in(mode),
    .row_top_out(top_o), .row_bot_out(bot_o), .row_valid_out(valid_o),
    .row_ready_in(ready), .row_address_out(addr_o), .frame_done_out(fd_o));

  always #5 clk = ~clk;

  // Model state: counts of completed frames and effect steps since the last restart
  int m_mode_buf, m_addr, m_steps, m_frames, m_tick;
  bit m_valid, m_fd, m_pending, m_rst_dly;
  logic [3*NC-1:0] m_top, m_bot;

  function automatic int bounce(int n, int maxv);
    int p;
    p = n % (2 * maxv);
    return (p <= maxv) ? p : 2 * maxv - p;
  endfunction

  function automatic logic [3*NC-1:0] exp_row(int md, int line, logic [3*CW-1:0] col, int steps, int frames);
    logic [3*NC-1:0] r;
    int ci, i;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        ci = int'(col[ch*CW +: CW]);
        case (md)
          1: i = ci;
          2: i = (c == bounce(steps, NC - 1)) ? ci : 0;
          3: i = (line == bounce(steps, 2 * NR - 1)) ? ci : 0;
          4: i = (ci * bounce(steps, IMAXV)) / (1 << CW);
          5: i = (((c ^ line ^ steps) & 1) == 1) ? ci : 0;
          default: i = 0;
        endcase
`ifdef LED_PATGEN_GAMMA_EN
        i = (i == IMAXV) ? IMAXV : (i * i) / (1 << CW);
`endif
        r[ch*NC + c] = (i > (frames % NPHASES));
      end
    end
    return r;
  endfunction

  task automatic model_update();
    bit t, ld;
    if (rst_in) begin
      m_valid = 0; m_addr = 0; m_fd = 0; m_top = '0; m_bot = '0; m_mode_buf = 0;
      m_steps = 0; m_frames = 0; m_pending = 0; m_tick = 0; m_rst_dly = 1;
      return;
    end
    t = (m_tick == ET - 1);
    m_tick = t ? 0 : m_tick + 1;
    m_fd = 0;
    ld = 0;
    if (int'(mode) != m_mode_buf) begin
      m_valid = 0; m_addr = 0; m_steps = 0; m_frames = 0; m_pending = 0;
    end else begin
      if (!m_valid) begin
        if (!m_rst_dly) begin m_valid = 1; m_addr = 0; ld = 1; end
        m_pending = m_pending | t;
      end else if (ready) begin
        ld = 1;
        if (m_addr == NR - 1) begin
          m_fd = 1; m_addr = 0; m_frames++;
          if (m_pending) m_steps++;
          m_pending = t;
        end else begin
          m_addr++;
          m_pending = m_pending | t;
        end
      end else begin
        m_pending = m_pending | t;
      end
      if (ld) begin
        m_top = exp_row(m_mode_buf, m_addr, colour, m_steps, m_frames);
        m_bot = exp_row(m_mode_buf, m_addr + NR, colour, m_steps, m_frames);
      end
    end
    m_mode_buf = int'(mode);
    m_rst_dly = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("model_valid", 64'(valid_o), 64'(m_valid));
    chk("model_frame_done", 64'(fd_o), 64'(m_fd));
    if (m_valid) begin
      chk("model_addr", 64'(addr_o), 64'(m_addr));
      chk("model_top", 64'(top_o), 64'(m_top));
      chk("model_bot", 64'(bot_o), 64'(m_bot));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic restart(input logic [3:0] md, input logic [3*CW-1:0] col);
    rst_in = 1'b1; mode = md; colour = col; ready = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  // Bounded wait for a given address to be presented; expiry counts as a miscompare.
  task automatic wait_addr(input int a, input string nm);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (valid_o === 1'b1 && int'(addr_o) == a) seen = 1;
      else step();
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  typedef struct {
    bit              rst;
    logic [3:0]      md;
    bit              rdy;
    bit              ev;
    int              ea;
    logic [3*NC-1:0] etop;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int on_cnt, frames_seen, lit;
    int hexp[14];

    tbl[0]  = '{1, 4'd1, 0, 0, 0, 24'h0};
    tbl[1]  = '{0, 4'd1, 0, 0, 0, 24'h0};
    tbl[2]  = '{0, 4'd1, 0, 1, 0, 24'h0000FF};
    tbl[3]  = '{0, 4'd1, 0, 1, 0, 24'h0000FF};
    tbl[4]  = '{0, 4'd1, 1, 1, 1, 24'h0000FF};
    tbl[5]  = '{0, 4'd1, 1, 1, 2, 24'h0000FF};
    tbl[6]  = '{0, 4'd1, 0, 1, 2, 24'h0000FF};
    tbl[7]  = '{0, 4'd2, 1, 0, 0, 24'h0};
    tbl[8]  = '{0, 4'd2, 1, 1, 0, 24'h000001};
    tbl[9]  = '{0, 4'd2, 1, 1, 1, 24'h000001};
    tbl[10] = '{1, 4'd2, 1, 0, 0, 24'h0};
    tbl[11] = '{0, 4'd0, 1, 0, 0, 24'h0};
    tbl[12] = '{0, 4'd0, 1, 1, 0, 24'h0};
    tbl[13] = '{0, 4'd0, 1, 1, 1, 24'h0};

    colour = 12'h00F;
    @(negedge clk);
    for (int v = 0; v < 14; v++) begin
      rst_in = tbl[v].rst; mode = tbl[v].md; ready = tbl[v].rdy;
      step();
      chk("tbl_valid", 64'(valid_o), 64'(tbl[v].ev));
      chk("tbl_fd", 64'(fd_o), 64'd0);
      if (tbl[v].ev) begin
        chk("tbl_addr", 64'(addr_o), 64'(tbl[v].ea));
        chk("tbl_top", 64'(top_o), 64'(tbl[v].etop));
        chk("tbl_bot", 64'(bot_o), 64'(tbl[v].etop));
      end
    end

    // Backpressure hold at address 5, then frame_done after address 15
    restart(4'd1, 12'h00F);
    wait_addr(5, "reach_addr5");
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_addr", 64'(addr_o), 64'd5);
      chk("hold_top", 64'(top_o), 64'h0000FF);
      chk("hold_bot", 64'(bot_o), 64'h0000FF);
    end
    ready = 1'b1;
    step();
    chk("release_addr", 64'(addr_o), 64'd6);
    wait_addr(15, "reach_addr15");
    step();
    chk("wrap_fd", 64'(fd_o), 64'd1);
    chk("wrap_addr", 64'(addr_o), 64'd0);

    // Mode change while presenting address 9 aborts the frame
    restart(4'd3, 12'h0F0);
    wait_addr(9, "reach_addr9");
    mode = 4'd1;
    step();
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_fd", 64'(fd_o), 64'd0);
    step();
    chk("restart_valid", 64'(valid_o), 64'd1);
    chk("restart_addr", 64'(addr_o), 64'd0);
    chk("restart_fd", 64'(fd_o), 64'd0);

    // PWM duty: red=8 is lit in 8 of 15 frames
    restart(4'd1, 12'h008);
    on_cnt = 0; frames_seen = 0;
    for (int k = 0; k < 400 && frames_seen < 15; k++) begin
      step();
      if (valid_o === 1'b1 && addr_o == '0) begin
        frames_seen++;
        if (top_o[0] === 1'b1) on_cnt++;
      end
    end
    chk("pwm_frames_seen", 64'(frames_seen), 64'd15);
    chk("pwm_on_frames", 64'(on_cnt), 64'(8));

    // hscan column per frame bounces 0..7..0
    hexp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
    restart(4'd2, 12'h00F);
    frames_seen = 0;
    for (int k = 0; k < 400 && frames_seen < 14; k++) begin
      step();
      if (valid_o === 1'b1 && addr_o == '0) begin
        lit = -1;
        for (int c = 0; c < NC; c++) if (top_o[c] === 1'b1) lit = (lit == -1) ? c : -2;
        chk("hscan_col", 64'(lit), 64'(hexp[frames_seen]));
        frames_seen++;
      end
    end
    chk("hscan_frames_seen", 64'(frames_seen), 64'd14);

    // Randomized run, every cycle compared against the model
    restart(4'd4, 12'h9C7);
    for (int k = 0; k < 4000; k++) begin
      rst_in = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0)
        mode = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
      if ($urandom_range(0, 39) == 0) colour = 12'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
